regfile_wb_ctrl: RTL and testbench

//  Writeback controller for reg_file's single write port. Round-robin arbitrates NUM_REQ writeback

---
 rtl/arm_core_pkg.sv | 10 +
 rtl/regfile_wb_ctrl_rr_arbiter.sv | 50 +++++
 rtl/regfile_wb_ctrl.sv | 109 ++++++++++
 tb/tb_regfile_wb_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_core_pkg.sv
// Shared constants for the core's integer register file and its writeback path.
package arm_core_pkg;

  // Index 31 names SP or XZR depending on the instruction's qualifier.
  localparam logic [4:0] REG_SP_XZR = 5'd31;
  localparam int         XREG_W     = 5;
  localparam int         XLEN       = 64;
  localparam int         NUM_WB_REQ = 3;

endpackage

// File: rtl/regfile_wb_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr, cyclically.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       advance,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_any
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] cand;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = wrap_add(rr_ptr, k);
      if (!grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  // The winner becomes lowest priority; the pointer only moves on an accepted grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (advance && grant_any) begin
      rr_ptr <= wrap_add(grant_idx, 1);
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: arbitrates results onto reg_file's single write port and keeps a
// per-register busy scoreboard for decode's RAW-hazard stall.
module regfile_wb_ctrl
  import arm_core_pkg::*;
#(
  parameter int NUM_REQ = NUM_WB_REQ,
  parameter int DATA_W  = XLEN,
  parameter int ADDR_W  = XREG_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_use_sp,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         Write_register,
  output logic [DATA_W-1:0]         Write_d,
  input  logic                      iss_valid,
  input  logic [ADDR_W-1:0]         iss_reg,
  input  logic                      iss_use_sp,
  input  logic [ADDR_W-1:0]         qry_reg_1,
  input  logic [ADDR_W-1:0]         qry_reg_2,
  input  logic                      qry_sp_1,
  input  logic                      qry_sp_2,
  output logic                      qry_busy_1,
  output logic                      qry_busy_2,
  input  logic                      flush
);

  localparam int                PTR_W    = $clog2(NUM_REQ);
  localparam int                NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] XZR_IDX  = ADDR_W'(REG_SP_XZR);

  // Handshake: a requester's result is taken in the cycle where req_valid[i] & req_ready[i].
  // req_ready is a one-hot (or zero) function of req_valid; requesters never wait on ready
  // before raising valid and hold reg/data/use_sp stable until the handshake.

  logic [NUM_REQ-1:0]  grant;
  logic [PTR_W-1:0]    grant_idx;
  logic                grant_any;
  logic                hs;
  logic [ADDR_W-1:0]   sel_reg;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_sp;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  function automatic logic is_xzr(input logic [ADDR_W-1:0] r, input logic sp);
    return (r == XZR_IDX) && !sp;
  endfunction

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .clk      (clk),
    .rst_n    (reset),
    .req      (req_valid),
    .advance  (hs),
    .grant    (grant),
    .grant_idx(grant_idx),
    .grant_any(grant_any)
  );

  assign req_ready = reset ? grant : '0;
  assign hs        = grant_any & reset;
  assign sel_reg   = req_reg[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign sel_data  = req_data[int'(grant_idx)*DATA_W +: DATA_W];
  assign sel_sp    = req_use_sp[grant_idx];

  // XZR results are accepted and discarded; index/data keep their last committed values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWrite       <= 1'b0;
      Write_register <= '0;
      Write_d        <= '0;
    end else if (hs && !is_xzr(sel_reg, sel_sp)) begin
      RegWrite       <= 1'b1;
      Write_register <= sel_reg;
      Write_d        <= sel_data;
    end else begin
      RegWrite       <= 1'b0;
    end
  end

  // Clear for the committing write first so a same-edge issue (younger producer) wins.
  always_comb begin
    busy_next = busy;
    if (RegWrite) busy_next[Write_register] = 1'b0;
    if (flush) begin
      busy_next = '0;
    end else if (iss_valid && !is_xzr(iss_reg, iss_use_sp)) begin
      busy_next[iss_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign qry_busy_1 = busy[qry_reg_1] & ~is_xzr(qry_reg_1, qry_sp_1);
  assign qry_busy_2 = busy[qry_reg_2] & ~is_xzr(qry_reg_2, qry_sp_2);

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed scenarios with literal expectations, then random
// traffic compared every cycle against a behavioural model of arbitration and scoreboard.
module tb_regfile_wb_ctrl;

  localparam int N  = 3;
  localparam int DW = 64;
  localparam int AW = 5;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic              r_v    [N];
  logic [AW-1:0]     r_reg  [N];
  logic [DW-1:0]     r_data [N];
  logic              r_sp   [N];

  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_reg;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_use_sp;
  logic              RegWrite;
  logic [AW-1:0]     Write_register;
  logic [DW-1:0]     Write_d;
  logic              iss_valid  = 1'b0;
  logic [AW-1:0]     iss_reg    = '0;
  logic              iss_use_sp = 1'b0;
  logic [AW-1:0]     qry_reg_1  = '0;
  logic [AW-1:0]     qry_reg_2  = '0;
  logic              qry_sp_1   = 1'b0;
  logic              qry_sp_2   = 1'b0;
  logic              qry_busy_1;
  logic              qry_busy_2;
  logic              flush      = 1'b0;

  always_comb begin
    req_valid  = '0;
    req_reg    = '0;
    req_data   = '0;
    req_use_sp = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = r_v[i];
      req_reg[i*AW +: AW]     = r_reg[i];
      req_data[i*DW +: DW]    = r_data[i];
      req_use_sp[i]           = r_sp[i];
    end
  end

  regfile_wb_ctrl #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_reg       (req_reg),
    .req_data      (req_data),
    .req_use_sp    (req_use_sp),
    .RegWrite      (RegWrite),
    .Write_register(Write_register),
    .Write_d       (Write_d),
    .iss_valid     (iss_valid),
    .iss_reg       (iss_reg),
    .iss_use_sp    (iss_use_sp),
    .qry_reg_1     (qry_reg_1),
    .qry_reg_2     (qry_reg_2),
    .qry_sp_1      (qry_sp_1),
    .qry_sp_2      (qry_sp_2),
    .qry_busy_1    (qry_busy_1),
    .qry_busy_2    (qry_busy_2),
    .flush         (flush)
  );

  // ---------------- model state and scoreboard ----------------
  int                 total = 0;
  int                 bad   = 0;
  int                 m_ptr = 0;
  bit                 m_busy [32];
  logic               m_we = 1'b0;
  logic [AW-1:0]      m_wr = '0;
  logic [DW-1:0]      m_wd = '0;
  logic [AW+DW-1:0]   exp_q[$];
  int                 last_hs = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit xzr(input logic [AW-1:0] r, input logic sp);
    return (r == 5'd31) && !sp;
  endfunction

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      if (r_v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_update();
    int g;
    if (!reset) begin
      m_ptr = 0;
      for (int k = 0; k < 32; k++) m_busy[k] = 1'b0;
      m_we = 1'b0;
      m_wr = '0;
      m_wd = '0;
      exp_q.delete();
      last_hs = -1;
    end else begin
      g = model_grant();
      if (m_we) m_busy[m_wr] = 1'b0;
      if (flush) begin
        for (int k = 0; k < 32; k++) m_busy[k] = 1'b0;
      end else if (iss_valid && !xzr(iss_reg, iss_use_sp)) begin
        m_busy[iss_reg] = 1'b1;
      end
      last_hs = g;
      m_we    = 1'b0;
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        if (!xzr(r_reg[g], r_sp[g])) begin
          m_we = 1'b1;
          m_wr = r_reg[g];
          m_wd = r_data[g];
          exp_q.push_back({r_reg[g], r_data[g]});
        end
      end
    end
  endtask

  // Compare process: mid-cycle, inputs stable since just after the previous rising edge.
  always @(negedge clk) begin : compare
    int               g;
    logic [N-1:0]     er;
    logic [AW+DW-1:0] wb;
    g  = model_grant();
    er = '0;
    if (reset && g >= 0) er[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("reg_write", 64'(RegWrite), 64'(reset && m_we));
    if (reset && m_we) begin
      chk("wb_queue_depth", 64'(exp_q.size()), 64'd1);
      if (exp_q.size() > 0) begin
        wb = exp_q.pop_front();
        chk("wb_index", 64'(Write_register), 64'(wb[AW+DW-1:DW]));
        chk("wb_data", Write_d, wb[DW-1:0]);
      end
    end else begin
      chk("hold_index", 64'(Write_register), reset ? 64'(m_wr) : 64'd0);
      chk("hold_data", Write_d, reset ? m_wd : 64'd0);
    end
    chk("qry_busy_1", 64'(qry_busy_1), 64'(reset && m_busy[qry_reg_1] && !xzr(qry_reg_1, qry_sp_1)));
    chk("qry_busy_2", 64'(qry_busy_2), 64'(reset && m_busy[qry_reg_2] && !xzr(qry_reg_2, qry_sp_2)));
    model_update();
  end

  // ---------------- driver tasks ----------------
  task automatic to_mid();
    @(negedge clk);
    #1;
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] r,
                         input logic [DW-1:0] d, input logic sp);
    r_v[i]    = v;
    r_reg[i]  = r;
    r_data[i] = d;
    r_sp[i]   = sp;
  endtask

  task automatic issue(input logic v, input logic [AW-1:0] r, input logic sp);
    iss_valid  = v;
    iss_reg    = r;
    iss_use_sp = sp;
  endtask

  function automatic logic [AW-1:0] rnd_reg();
    if ($urandom_range(0, 3) == 0) return 5'd31;
    return AW'($urandom_range(0, 7));
  endfunction

  logic [N-1:0] rr_exp [6];

  initial begin
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100;
    rr_exp[3] = 3'b001; rr_exp[4] = 3'b010; rr_exp[5] = 3'b100;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), DW'(64'h100 + i), 1'b0);

    // Reset held with every requester valid.
    to_mid();
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_regwrite", 64'(RegWrite), 64'd0);
    chk("rst_qry", 64'(qry_busy_1), 64'd0);
    to_drive();
    reset = 1'b1;

    // Round-robin over three always-valid requesters.
    for (int c = 0; c < 6; c++) begin
      to_mid();
      chk("rr_grant", 64'(req_ready), 64'(rr_exp[c]));
      if (c > 0) begin
        chk("rr_regwrite", 64'(RegWrite), 64'd1);
        chk("rr_index", 64'(Write_register), 64'((c - 1) % 3 + 1));
      end
      to_drive();
    end
    for (int i = 0; i < N; i++) r_v[i] = 1'b0;
    to_mid();
    chk("rr_last_index", 64'(Write_register), 64'd3);

    // One-cycle latency on requester 1.
    to_drive();
    set_req(1, 1'b1, 5'd5, 64'hDEAD, 1'b0);
    to_mid();
    chk("lat_ready", 64'(req_ready), 64'b010);
    to_drive();
    r_v[1] = 1'b0;
    to_mid();
    chk("lat_regwrite", 64'(RegWrite), 64'd1);
    chk("lat_index", 64'(Write_register), 64'd5);
    chk("lat_data", Write_d, 64'hDEAD);

    // XZR discard, then SP write clearing busy[31].
    to_drive();
    set_req(0, 1'b1, 5'd31, 64'h1111, 1'b0);
    issue(1'b1, 5'd31, 1'b1);
    to_mid();
    chk("xzr_ready", 64'(req_ready), 64'b001);
    to_drive();
    r_v[0] = 1'b0;
    issue(1'b0, 5'd0, 1'b0);
    qry_reg_1 = 5'd31; qry_sp_1 = 1'b1;
    qry_reg_2 = 5'd31; qry_sp_2 = 1'b0;
    to_mid();
    chk("xzr_regwrite", 64'(RegWrite), 64'd0);
    chk("sp_busy", 64'(qry_busy_1), 64'd1);
    chk("xzr_qry", 64'(qry_busy_2), 64'd0);
    to_drive();
    set_req(2, 1'b1, 5'd31, 64'h5555, 1'b1);
    to_mid();
    chk("sp_ready", 64'(req_ready), 64'b100);
    to_drive();
    r_v[2] = 1'b0;
    to_mid();
    chk("sp_regwrite", 64'(RegWrite), 64'd1);
    chk("sp_busy_during", 64'(qry_busy_1), 64'd1);
    to_drive();
    to_mid();
    chk("sp_busy_after", 64'(qry_busy_1), 64'd0);

    // Scoreboard on X7, then re-issue in the commit cycle.
    to_drive();
    issue(1'b1, 5'd7, 1'b0);
    qry_reg_1 = 5'd7; qry_sp_1 = 1'b0;
    to_mid();
    chk("x7_before", 64'(qry_busy_1), 64'd0);
    to_drive();
    issue(1'b0, 5'd0, 1'b0);
    set_req(0, 1'b1, 5'd7, 64'h77, 1'b0);
    to_mid();
    chk("x7_busy", 64'(qry_busy_1), 64'd1);
    to_drive();
    r_v[0] = 1'b0;
    to_mid();
    chk("x7_commit_wr", 64'(RegWrite), 64'd1);
    chk("x7_busy_commit", 64'(qry_busy_1), 64'd1);
    to_drive();
    to_mid();
    chk("x7_cleared", 64'(qry_busy_1), 64'd0);
    to_drive();
    issue(1'b1, 5'd7, 1'b0);
    to_drive();
    issue(1'b0, 5'd0, 1'b0);
    set_req(1, 1'b1, 5'd7, 64'h78, 1'b0);
    to_drive();
    r_v[1] = 1'b0;
    issue(1'b1, 5'd7, 1'b0);
    to_mid();
    chk("x7_commit_wr2", 64'(RegWrite), 64'd1);
    to_drive();
    issue(1'b0, 5'd0, 1'b0);
    to_mid();
    chk("x7_set_wins", 64'(qry_busy_1), 64'd1);

    // Flush with a simultaneous issue and a committing write.
    to_drive();
    issue(1'b1, 5'd3, 1'b0);
    to_drive();
    issue(1'b1, 5'd9, 1'b0);
    set_req(2, 1'b1, 5'd20, 64'h2020, 1'b0);
    to_drive();
    r_v[2] = 1'b0;
    issue(1'b1, 5'd4, 1'b0);
    flush = 1'b1;
    to_mid();
    chk("flush_commit_wr", 64'(RegWrite), 64'd1);
    chk("flush_commit_idx", 64'(Write_register), 64'd20);
    to_drive();
    issue(1'b0, 5'd0, 1'b0);
    flush = 1'b0;
    qry_reg_1 = 5'd3; qry_reg_2 = 5'd9;
    to_mid();
    chk("flush_x3", 64'(qry_busy_1), 64'd0);
    chk("flush_x9", 64'(qry_busy_2), 64'd0);
    to_drive();
    qry_reg_1 = 5'd4; qry_reg_2 = 5'd7;
    to_mid();
    chk("flush_x4", 64'(qry_busy_1), 64'd0);
    chk("flush_x7", 64'(qry_busy_2), 64'd0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      to_drive();
      for (int i = 0; i < N; i++) begin
        if (!r_v[i] || last_hs == i) begin
          set_req(i, 1'($urandom_range(0, 1)), rnd_reg(), {$urandom, $urandom},
                  1'($urandom_range(0, 1)));
        end
      end
      issue(1'($urandom_range(0, 2) == 0), rnd_reg(), 1'($urandom_range(0, 1)));
      flush     = ($urandom_range(0, 19) == 0);
      qry_reg_1 = rnd_reg(); qry_sp_1 = 1'($urandom_range(0, 1));
      qry_reg_2 = rnd_reg(); qry_sp_2 = 1'($urandom_range(0, 1));
      reset     = ($urandom_range(0, 299) != 0);
    end
    to_drive();
    reset = 1'b1;
    for (int i = 0; i < N; i++) r_v[i] = 1'b0;
    issue(1'b0, 5'd0, 1'b0);
    flush = 1'b0;
    to_drive();
    to_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
